// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and LED mask layout for the PS/2 lock LED controller.
package ps2_pkg;

  // Host-to-keyboard command and keyboard responses
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  // Scan-code prefixes and lock key codes (set 2)
  localparam logic [7:0] CODE_BREAK   = 8'hF0;
  localparam logic [7:0] CODE_EXT     = 8'hE0;
  localparam logic [7:0] KEY_NUM      = 8'h77;
  localparam logic [7:0] KEY_CAPS     = 8'h58;
  localparam logic [7:0] KEY_SCROLL   = 8'h7E;

  // Bit positions inside the Set LEDs mask byte; the LED vector uses the same order
  localparam int LED_SCROLL_BIT = 0;
  localparam int LED_NUM_BIT    = 1;
  localparam int LED_CAPS_BIT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_ACK1,
    ST_SEND_MASK,
    ST_WAIT_ACK2
  } seq_state_t;

  // Builds the mask byte sent after 0xED from the LED vector
  function automatic logic [7:0] led_mask(input logic [2:0] leds);
    return {5'b0, leds};
  endfunction

endpackage

// File: rtl/ps2_lock_led_ctrl_if.sv
// Receive strobe/byte and transmit handshake between the controller and the PS/2 PHY.
interface ps2_lock_led_ctrl_if;
  logic       code_new_updated;
  logic [7:0] check_code;
  logic       tx_ready;
  logic       tx_req;
  logic [7:0] tx_data;

  modport master (
    input  code_new_updated, check_code, tx_ready,
    output tx_req, tx_data
  );

  modport slave (
    output code_new_updated, check_code, tx_ready,
    input  tx_req, tx_data
  );
endinterface

// File: rtl/ps2_lock_decode.sv
// Scan-code decoder: tracks break/extended prefixes, held lock keys and lock LED state.
module ps2_lock_decode
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic [2:0] leds,
  output logic       toggle
);

  logic       brk_flag;
  logic       ext_flag;
  logic [2:0] held;
  logic [2:0] key_sel;

  // Identify which lock key (if any) this byte is, and whether it toggles an LED now
  always_comb begin
    key_sel = '0;
    if (!ext_flag) begin
      case (code)
        KEY_NUM:    key_sel[LED_NUM_BIT]    = 1'b1;
        KEY_CAPS:   key_sel[LED_CAPS_BIT]   = 1'b1;
        KEY_SCROLL: key_sel[LED_SCROLL_BIT] = 1'b1;
        default:    key_sel = '0;
      endcase
    end
    toggle = code_valid && !brk_flag && (|(key_sel & ~held));
  end

  // Prefix flags, held bits and LED toggles; a make of an already-held key is typematic and ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_flag <= 1'b0;
      ext_flag <= 1'b0;
      held     <= '0;
      leds     <= '0;
    end else if (code_valid) begin
      if (code == CODE_BREAK) begin
        brk_flag <= 1'b1;
      end else if (code == CODE_EXT) begin
        ext_flag <= 1'b1;
      end else begin
        brk_flag <= 1'b0;
        ext_flag <= 1'b0;
        if (brk_flag) begin
          held <= held & ~key_sel;
        end else begin
          held <= held | key_sel;
          leds <= leds ^ (key_sel & ~held);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_lock_led_ctrl.sv
// Lock LED controller: local lock LEDs plus the 0xED/mask sequence that mirrors them on the keyboard.
module ps2_lock_led_ctrl
  import ps2_pkg::*;
#(
  parameter logic [11:0] TIMEOUT_TICKS = 12'd3000,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                       clk_2,
  input  logic                       rst_n,
  input  logic                       clk_300k,
  ps2_lock_led_ctrl_if.master        bus,
  output logic                       led_num,
  output logic                       led_caps,
  output logic                       led_scroll,
  output logic                       busy,
  output logic                       error
);

  localparam logic [3:0] MAX_R = MAX_RETRY[3:0];

  seq_state_t  state, state_nx;
  logic [3:0]  retry, retry_nx;
  logic [11:0] tmo, tmo_nx;
  logic        error_nx;
  logic        tx_req_q, tx_req_nx;
  logic [7:0]  tx_data_q, tx_data_nx;
  logic        dirty, dirty_nx;
  logic [2:0]  leds;
  logic        toggle;
  logic        in_wait;
  logic        is_ack;
  logic        is_resend;
  logic        timed_out;

  assign in_wait   = (state == ST_WAIT_ACK1) || (state == ST_WAIT_ACK2);
  assign is_ack    = in_wait && bus.code_new_updated && (bus.check_code == RSP_ACK);
  assign is_resend = in_wait && bus.code_new_updated && (bus.check_code == RSP_RESEND);
  assign timed_out = in_wait && (tmo >= TIMEOUT_TICKS);

  ps2_lock_decode u_decode (
    .clk        (clk_2),
    .rst_n      (rst_n),
    .code_valid (bus.code_new_updated && !(is_ack || is_resend)),
    .code       (bus.check_code),
    .leds       (leds),
    .toggle     (toggle)
  );

  // Sequencer next-state logic; a received ACK/RESEND takes priority over a coincident timeout
  always_comb begin
    state_nx   = state;
    retry_nx   = retry;
    tmo_nx     = tmo;
    error_nx   = error;
    tx_req_nx  = tx_req_q;
    tx_data_nx = tx_data_q;
    dirty_nx   = dirty | toggle;

    if (in_wait && clk_300k && (tmo != 12'hFFF)) begin
      tmo_nx = tmo + 12'd1;
    end

    case (state)
      ST_IDLE: begin
        if (dirty) begin
          dirty_nx   = toggle;
          state_nx   = ST_SEND_CMD;
          retry_nx   = '0;
          tx_req_nx  = 1'b1;
          tx_data_nx = CMD_SET_LEDS;
        end
      end
      ST_SEND_CMD, ST_SEND_MASK: begin
        if (tx_req_q && bus.tx_ready) begin
          state_nx  = (state == ST_SEND_CMD) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
          tmo_nx    = '0;
          tx_req_nx = 1'b0;
        end
      end
      ST_WAIT_ACK1: begin
        if (is_ack) begin
          state_nx   = ST_SEND_MASK;
          retry_nx   = '0;
          tx_req_nx  = 1'b1;
          tx_data_nx = led_mask(leds);
        end else if (is_resend || timed_out) begin
          if (retry < MAX_R) begin
            retry_nx   = retry + 4'd1;
            state_nx   = ST_SEND_CMD;
            tx_req_nx  = 1'b1;
            tx_data_nx = CMD_SET_LEDS;
          end else begin
            error_nx = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_WAIT_ACK2: begin
        if (is_ack) begin
          error_nx = 1'b0;
          state_nx = ST_IDLE;
        end else if (is_resend || timed_out) begin
          if (retry < MAX_R) begin
            retry_nx   = retry + 4'd1;
            state_nx   = ST_SEND_MASK;
            tx_req_nx  = 1'b1;
            tx_data_nx = led_mask(leds);
          end else begin
            error_nx = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx  = ST_IDLE;
        tx_req_nx = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset aborts any transaction and drops tx_req immediately
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      retry     <= '0;
      tmo       <= '0;
      error     <= 1'b0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      dirty     <= 1'b0;
    end else begin
      state     <= state_nx;
      retry     <= retry_nx;
      tmo       <= tmo_nx;
      error     <= error_nx;
      tx_req_q  <= tx_req_nx;
      tx_data_q <= tx_data_nx;
      dirty     <= dirty_nx;
    end
  end

  assign bus.tx_req  = tx_req_q;
  assign bus.tx_data = tx_data_q;
  assign busy        = (state != ST_IDLE);
  assign led_num     = leds[LED_NUM_BIT];
  assign led_caps    = leds[LED_CAPS_BIT];
  assign led_scroll  = leds[LED_SCROLL_BIT];

endmodule

// File: tb/tb_ps2_lock_led_ctrl.sv
// Directed self-checking bench for ps2_lock_led_ctrl (short timeout for simulation speed).
module tb_ps2_lock_led_ctrl;

  localparam logic [11:0] TB_TIMEOUT = 12'd8;

  logic clk_2;
  logic rst_n;
  logic clk_300k;
  logic led_num, led_caps, led_scroll, busy, error;

  int checks = 0;
  int errors = 0;

  ps2_lock_led_ctrl_if bus ();

  ps2_lock_led_ctrl #(
    .TIMEOUT_TICKS (TB_TIMEOUT),
    .MAX_RETRY     (3)
  ) dut (
    .clk_2      (clk_2),
    .rst_n      (rst_n),
    .clk_300k   (clk_300k),
    .bus        (bus.master),
    .led_num    (led_num),
    .led_caps   (led_caps),
    .led_scroll (led_scroll),
    .busy       (busy),
    .error      (error)
  );

  // 100 MHz-style system clock
  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  // Tick enable: one cycle high out of every five
  initial begin
    clk_300k = 1'b0;
    forever begin
      repeat (4) @(negedge clk_2);
      clk_300k = 1'b1;
      @(negedge clk_2);
      clk_300k = 1'b0;
    end
  end

  // Global watchdog so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sends one received byte as a single-cycle strobe; entered and left on a negedge
  task automatic send_byte(input logic [7:0] b);
    bus.code_new_updated = 1'b1;
    bus.check_code       = b;
    @(negedge clk_2);
    bus.code_new_updated = 1'b0;
    bus.check_code       = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  // Waits (bounded) for tx_req, captures tx_data, then accepts it for one cycle
  task automatic wait_tx(output bit found, output logic [7:0] data, output int waited);
    found  = 1'b0;
    data   = 8'h00;
    waited = 0;
    while (!found && waited < 200) begin
      if (bus.tx_req === 1'b1) found = 1'b1;
      else begin
        @(negedge clk_2);
        waited++;
      end
    end
    if (found) begin
      data = bus.tx_data;
      bus.tx_ready = 1'b1;
      @(negedge clk_2);
      bus.tx_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.code_new_updated = 1'b0;
    bus.check_code = 8'h00;
    bus.tx_ready = 1'b0;
    idle_cycles(3);
    checks++;
    if ({led_num, led_caps, led_scroll, busy, error, bus.tx_req} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {led_num, led_caps, led_scroll, busy, error, bus.tx_req});
    end
    rst_n = 1'b1;
    idle_cycles(3);
    checks++;
    if ({led_num, led_caps, led_scroll, busy, error, bus.tx_req} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got %b expected 000000",
               {led_num, led_caps, led_scroll, busy, error, bus.tx_req});
    end
  endtask

  task automatic test_num_basic;
    bit found; logic [7:0] d; int w;
    send_byte(8'h77);
    checks++;
    if (led_num !== 1'b1) begin errors++; $display("[TB] FAIL num_toggle: got %b expected 1", led_num); end
    @(negedge clk_2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL num_busy: got %b expected 1", busy); end
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'hED) begin errors++; $display("[TB] FAIL num_cmd: got %h (found %0d) expected ed", d, found); end
    checks++;
    if (bus.tx_req !== 1'b0) begin errors++; $display("[TB] FAIL tx_req_drop: got %b expected 0", bus.tx_req); end
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h02) begin errors++; $display("[TB] FAIL num_mask: got %h (found %0d) expected 02", d, found); end
    send_byte(8'hFA);
    @(negedge clk_2);
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("[TB] FAIL num_done: busy/error got %b%b expected 00", busy, error);
    end
    send_byte(8'hF0);
    send_byte(8'h77);
    idle_cycles(5);
    checks++;
    if (busy !== 1'b0 || led_num !== 1'b1) begin
      errors++; $display("[TB] FAIL num_release: busy/num got %b%b expected 01", busy, led_num);
    end
  endtask

  task automatic test_typematic;
    bit found; logic [7:0] d; int w;
    send_byte(8'h58);
    checks++;
    if (led_caps !== 1'b1) begin errors++; $display("[TB] FAIL caps_press: got %b expected 1", led_caps); end
    repeat (3) send_byte(8'h58);
    send_byte(8'hF0);
    send_byte(8'h58);
    checks++;
    if (led_caps !== 1'b1) begin errors++; $display("[TB] FAIL caps_typematic: got %b expected 1", led_caps); end
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'hED) begin errors++; $display("[TB] FAIL caps_cmd: got %h (found %0d) expected ed", d, found); end
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h06) begin errors++; $display("[TB] FAIL caps_mask: got %h (found %0d) expected 06", d, found); end
    send_byte(8'hFA);
    idle_cycles(5);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL caps_no_extra_txn: busy got %b expected 0", busy); end
    send_byte(8'h58);
    checks++;
    if (led_caps !== 1'b0) begin errors++; $display("[TB] FAIL caps_second_press: got %b expected 0", led_caps); end
    wait_tx(found, d, w);
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h02) begin errors++; $display("[TB] FAIL caps_off_mask: got %h (found %0d) expected 02", d, found); end
    send_byte(8'hFA);
    send_byte(8'hF0);
    send_byte(8'h58);
  endtask

  task automatic test_ignored;
    send_byte(8'hE0);
    send_byte(8'h77);
    send_byte(8'hF0);
    send_byte(8'h7E);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h77);
    idle_cycles(5);
    checks++;
    if ({led_caps, led_num, led_scroll, busy} !== 4'b0100) begin
      errors++; $display("[TB] FAIL ignored_codes: caps/num/scroll/busy got %b expected 0100",
                         {led_caps, led_num, led_scroll, busy});
    end
  endtask

  task automatic test_resend;
    bit found; logic [7:0] d; int w;
    send_byte(8'h7E);
    checks++;
    if (led_scroll !== 1'b1) begin errors++; $display("[TB] FAIL scroll_press: got %b expected 1", led_scroll); end
    wait_tx(found, d, w);
    send_byte(8'hFE);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'hED) begin errors++; $display("[TB] FAIL cmd_resend: got %h (found %0d) expected ed", d, found); end
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h03) begin errors++; $display("[TB] FAIL resend_mask: got %h (found %0d) expected 03", d, found); end
    send_byte(8'hFE);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h03) begin errors++; $display("[TB] FAIL mask_resend: got %h (found %0d) expected 03", d, found); end
    send_byte(8'hFA);
    @(negedge clk_2);
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("[TB] FAIL resend_done: busy/error got %b%b expected 00", busy, error);
    end
    send_byte(8'hF0);
    send_byte(8'h7E);
  endtask

  task automatic test_timeout;
    bit found; logic [7:0] d; int w; int n;
    send_byte(8'h7E);
    wait_tx(found, d, w);
    for (int i = 0; i < 3; i++) begin
      wait_tx(found, d, w);
      checks++;
      if (!found || d !== 8'hED || w < 30 || w > 50) begin
        errors++; $display("[TB] FAIL timeout_resend%0d: got %h after %0d cycles (found %0d) expected ed after 30..50",
                           i, d, w, found);
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin @(negedge clk_2); n++; end
    checks++;
    if (busy !== 1'b0 || error !== 1'b1 || bus.tx_req !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_abandon: busy/error/tx_req got %b%b%b expected 010",
                         busy, error, bus.tx_req);
    end
    send_byte(8'hF0);
    send_byte(8'h7E);
    send_byte(8'h58);
    wait_tx(found, d, w);
    checks++;
    if (error !== 1'b1) begin errors++; $display("[TB] FAIL error_sticky: got %b expected 1", error); end
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h06) begin errors++; $display("[TB] FAIL recover_mask: got %h (found %0d) expected 06", d, found); end
    send_byte(8'hFA);
    @(negedge clk_2);
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL error_cleared: busy/error got %b%b expected 00", busy, error);
    end
  endtask

  task automatic test_reset_abort;
    send_byte(8'h77);
    idle_cycles(2);
    checks++;
    if (bus.tx_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_setup: tx_req got %b expected 1", bus.tx_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_req, busy, led_num, led_caps} !== 4'b0000) begin
      errors++; $display("[TB] FAIL async_abort: tx_req/busy/num/caps got %b expected 0000",
                         {bus.tx_req, busy, led_num, led_caps});
    end
    @(negedge clk_2);
    rst_n = 1'b1;
    @(negedge clk_2);
  endtask

  task automatic test_back_to_back;
    bit found; logic [7:0] d; int w;
    send_byte(8'h77);
    wait_tx(found, d, w);
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h02) begin errors++; $display("[TB] FAIL b2b_first_mask: got %h (found %0d) expected 02", d, found); end
    send_byte(8'h7E);
    checks++;
    if (led_scroll !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_scroll_now: scroll/busy got %b%b expected 11", led_scroll, busy);
    end
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'hED) begin errors++; $display("[TB] FAIL b2b_second_cmd: got %h (found %0d) expected ed", d, found); end
    send_byte(8'hFA);
    wait_tx(found, d, w);
    checks++;
    if (!found || d !== 8'h03) begin errors++; $display("[TB] FAIL b2b_second_mask: got %h (found %0d) expected 03", d, found); end
    send_byte(8'hFA);
    idle_cycles(4);
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_done: busy/error got %b%b expected 00", busy, error);
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_num_basic();
    test_typematic();
    test_ignored();
    test_resend();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
